// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-side memory/I/O controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        R_CONST = 2'd0,
        R_VAR   = 2'd1,
        R_IO    = 2'd2,
        R_NONE  = 2'd3
    } region_e;

    // Byte offsets of the I/O registers inside the 16-byte bank
    localparam logic [3:0] LED_OFS  = 4'h0;
    localparam logic [3:0] SSEG_OFS = 4'h4;
    localparam logic [3:0] DIP_OFS  = 4'h8;
    localparam logic [3:0] CYC_OFS  = 4'hC;

    // True when addr lies in [base, base+len); written to avoid overflow of base+len
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] len);
        return (addr >= base) && ((addr - base) < len);
    endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port word RAM with byte-lane writes and a registered read port.
// Latency: read data valid 1 cycle after an enabled edge; writes commit on that edge.
// Backpressure: none; read register holds its value while en is low.
module mem_bus_ram #(
    parameter int    DEPTH     = 128,
    parameter string INIT_FILE = "",
    localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdat,
    output logic [31:0]   rdat
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdat_q;

    // Byte-lane write and read-before-write sample on enabled edges
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdat[8*i +: 8];
                    end
                end
            end
            rdat_q <= mem[addr];
        end
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-port decoder for constant ROM, variable RAM and an LED/7-seg/DIP/cycle I/O bank.
// Latency: READY/RDATA/FAULT exactly 1 cycle after the accepting edge; 1 access per cycle.
// Backpressure: none; every REQ edge is accepted, responses hold until the next acceptance.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int          CONST_DEPTH     = 128,
    parameter int          VAR_DEPTH       = 128,
    parameter logic [31:0] CONST_BASE      = 32'h200,
    parameter logic [31:0] VAR_BASE        = 32'h800,
    parameter logic [31:0] IO_BASE         = 32'hC00,
    parameter string       CONST_INIT_FILE = "const.mem",
    parameter int          N_LEDs          = 16,
    parameter int          N_DIPs          = 7
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ,
    input  logic              WE,
    input  logic [3:0]        BE,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       WDATA,
    output logic [31:0]       RDATA,
    output logic              READY,
    output logic              FAULT,
    input  logic [N_DIPs-1:0] DIP,
    output logic [N_LEDs-1:0] LED,
    output logic [31:0]       SEVENSEGHEX
);

    localparam int          CAW         = (CONST_DEPTH > 1) ? $clog2(CONST_DEPTH) : 1;
    localparam int          VAW         = (VAR_DEPTH > 1) ? $clog2(VAR_DEPTH) : 1;
    localparam logic [31:0] CONST_BYTES = 32'(4 * CONST_DEPTH);
    localparam logic [31:0] VAR_BYTES   = 32'(4 * VAR_DEPTH);

    state_e              state_q, state_d;
    region_e             sel_q, sel_d;
    logic                fault_q, fault_d;
    logic [31:0]         io_rdat_q, io_rdat_d;
    logic [N_LEDs-1:0]   led_q, led_d;
    logic [31:0]         sseg_q, sseg_d;
    logic [31:0]         cyc_q, cyc_d;
    logic [N_DIPs-1:0]   dip_s1_q, dip_s1_d;
    logic [N_DIPs-1:0]   dip_s2_q, dip_s2_d;

    region_e             region;
    logic                illegal;
    logic                acc_ok;
    logic                io_wr;
    logic [3:0]          io_ofs;
    logic [CAW-1:0]      const_idx;
    logic [VAW-1:0]      var_idx;
    logic [31:0]         const_rdat;
    logic [31:0]         var_rdat;

    assign io_ofs    = 4'(ADDR - IO_BASE);
    assign const_idx = CAW'((ADDR - CONST_BASE) >> 2);
    assign var_idx   = VAW'((ADDR - VAR_BASE) >> 2);

    // Address decode and legality of the access presented this cycle
    always_comb begin
        region = R_NONE;
        if (in_window(ADDR, CONST_BASE, CONST_BYTES)) begin
            region = R_CONST;
        end else if (in_window(ADDR, VAR_BASE, VAR_BYTES)) begin
            region = R_VAR;
        end else if (in_window(ADDR, IO_BASE, 32'd16)) begin
            region = R_IO;
        end
        illegal = (ADDR[1:0] != 2'b00) || (region == R_NONE)
               || (WE && region == R_CONST)
               || (WE && region == R_IO && io_ofs == DIP_OFS);
    end

    assign acc_ok = REQ && !illegal;
    assign io_wr  = acc_ok && WE && (region == R_IO);

    mem_bus_ram #(.DEPTH(CONST_DEPTH), .INIT_FILE(CONST_INIT_FILE)) u_const_rom (
        .clk  (CLK),
        .en   (acc_ok && region == R_CONST),
        .we   (1'b0),
        .be   (BE),
        .addr (const_idx),
        .wdat (WDATA),
        .rdat (const_rdat)
    );

    mem_bus_ram #(.DEPTH(VAR_DEPTH), .INIT_FILE("")) u_var_ram (
        .clk  (CLK),
        .en   (acc_ok && region == R_VAR),
        .we   (WE),
        .be   (BE),
        .addr (var_idx),
        .wdat (WDATA),
        .rdat (var_rdat)
    );

    // Next-state: handshake FSM, response capture, I/O registers, counter, DIP sync
    always_comb begin
        state_d   = REQ ? RESP : IDLE;
        sel_d     = sel_q;
        fault_d   = fault_q;
        io_rdat_d = io_rdat_q;
        led_d     = led_q;
        sseg_d    = sseg_q;
        cyc_d     = cyc_q + 32'd1;
        dip_s1_d  = DIP;
        dip_s2_d  = dip_s1_q;
        if (REQ) begin
            fault_d   = illegal;
            sel_d     = (illegal || WE) ? R_NONE : region;
            io_rdat_d = 32'd0;
            case (io_ofs)
                LED_OFS:  io_rdat_d = 32'(led_q);
                SSEG_OFS: io_rdat_d = sseg_q;
                DIP_OFS:  io_rdat_d = 32'(dip_s2_q);
                CYC_OFS:  io_rdat_d = cyc_q;
                default:  io_rdat_d = 32'd0;
            endcase
        end
        if (io_wr && io_ofs == LED_OFS)  led_d  = WDATA[N_LEDs-1:0];
        if (io_wr && io_ofs == SSEG_OFS) sseg_d = WDATA;
        // A clear wins over the free-running increment on the same edge
        if (io_wr && io_ofs == CYC_OFS)  cyc_d  = 32'd0;
    end

    // All control and I/O state; reset abandons any in-flight response
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            sel_q     <= R_NONE;
            fault_q   <= 1'b0;
            io_rdat_q <= 32'd0;
            led_q     <= '0;
            sseg_q    <= 32'd0;
            cyc_q     <= 32'd0;
            dip_s1_q  <= '0;
            dip_s2_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            fault_q   <= fault_d;
            io_rdat_q <= io_rdat_d;
            led_q     <= led_d;
            sseg_q    <= sseg_d;
            cyc_q     <= cyc_d;
            dip_s1_q  <= dip_s1_d;
            dip_s2_q  <= dip_s2_d;
        end
    end

    // Response data comes from whichever registered source the last acceptance chose
    always_comb begin
        case (sel_q)
            R_CONST: RDATA = const_rdat;
            R_VAR:   RDATA = var_rdat;
            R_IO:    RDATA = io_rdat_q;
            default: RDATA = 32'd0;
        endcase
    end

    assign READY       = (state_q == RESP);
    assign FAULT       = fault_q;
    assign LED         = led_q;
    assign SEVENSEGHEX = sseg_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, hand sequences, random traffic.
// Latency: expects response one cycle after each accepting edge.
// Backpressure: n/a.
module tb_mem_bus_ctrl;

    localparam logic [31:0] CB  = 32'h200;
    localparam logic [31:0] VB  = 32'h800;
    localparam logic [31:0] IOB = 32'hC00;
    localparam int          CD  = 128;
    localparam int          VD  = 128;

    logic        CLK, RESET_N, REQ, WE, READY, FAULT;
    logic [3:0]  BE;
    logic [31:0] ADDR, WDATA, RDATA, SEVENSEGHEX;
    logic [6:0]  DIP;
    logic [15:0] LED;

    mem_bus_ctrl #(
        .CONST_DEPTH(CD), .VAR_DEPTH(VD), .CONST_BASE(CB), .VAR_BASE(VB), .IO_BASE(IOB),
        .CONST_INIT_FILE(""), .N_LEDs(16), .N_DIPs(7)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .WE(WE), .BE(BE), .ADDR(ADDR),
        .WDATA(WDATA), .RDATA(RDATA), .READY(READY), .FAULT(FAULT), .DIP(DIP),
        .LED(LED), .SEVENSEGHEX(SEVENSEGHEX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_rom [CD];
    logic [31:0] m_ram [VD];
    logic [15:0] m_led;
    logic [31:0] m_sseg;
    logic [6:0]  m_dip_hist [2];   // [0] = DIP at last edge, [1] = DIP two edges back
    int          edges;
    int          clear_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_led         = 16'h0;
        m_sseg        = 32'h0;
        clear_edge    = edges;
        m_dip_hist[0] = 7'h0;
        m_dip_hist[1] = 7'h0;
    endtask

    // Expected outcome of one access accepted on the coming edge, plus its side effects
    task automatic model_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd, output logic flt);
        int idx;
        rd  = 32'h0;
        flt = 1'b0;
        if (addr % 4 != 0) begin
            flt = 1'b1;
        end else if (addr >= CB && addr < CB + 4 * CD) begin
            idx = int'((addr - CB) / 4);
            if (we) flt = 1'b1;
            else    rd  = m_rom[idx];
        end else if (addr >= VB && addr < VB + 4 * VD) begin
            idx = int'((addr - VB) / 4);
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_ram[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = m_ram[idx];
            end
        end else if (addr >= IOB && addr < IOB + 16) begin
            case (addr - IOB)
                32'd0:   if (we) m_led = wdata[15:0]; else rd = {16'h0, m_led};
                32'd4:   if (we) m_sseg = wdata;      else rd = m_sseg;
                32'd8:   if (we) flt = 1'b1;          else rd = {25'h0, m_dip_hist[1]};
                default: if (we) clear_edge = edges + 1; else rd = 32'(edges - clear_edge);
            endcase
        end else begin
            flt = 1'b1;
        end
    endtask

    // Present one cycle of inputs, advance one edge, compare against the model
    task automatic step(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] e_rd;
        logic        e_flt;
        REQ = req; WE = we; BE = be; ADDR = addr; WDATA = wdata;
        e_rd = 32'h0; e_flt = 1'b0;
        if (req) model_access(we, be, addr, wdata, e_rd, e_flt);
        @(posedge CLK);
        #1;
        edges++;
        m_dip_hist[1] = m_dip_hist[0];
        m_dip_hist[0] = DIP;
        check("ready", {31'h0, READY}, {31'h0, req});
        if (req) begin
            check("fault", {31'h0, FAULT}, {31'h0, e_flt});
            if (!we || e_flt) check("rdata", RDATA, e_rd);
        end
        check("led", {16'h0, LED}, {16'h0, m_led});
        check("sseg", SEVENSEGHEX, m_sseg);
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ready;
        logic        exp_fault;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
        logic [31:0] exp_sseg;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        logic [31:0] a;
        vecs[0]  = '{1'b0, 1'b0, 4'h0, 32'h000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'h0,    32'h0};
        vecs[1]  = '{1'b1, 1'b0, 4'hF, 32'h200, 32'h0,        1'b1, 1'b0, 1'b1, 32'h810,      16'h0,    32'h0};
        vecs[2]  = '{1'b1, 1'b1, 4'h5, 32'h804, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0, 32'h0,        16'h0,    32'h0};
        vecs[3]  = '{1'b1, 1'b0, 4'hF, 32'h804, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00BB00DD, 16'h0,    32'h0};
        vecs[4]  = '{1'b1, 1'b1, 4'hF, 32'h200, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h0,        16'h0,    32'h0};
        vecs[5]  = '{1'b1, 1'b0, 4'hF, 32'h1000, 32'h0,       1'b1, 1'b1, 1'b1, 32'h0,        16'h0,    32'h0};
        vecs[6]  = '{1'b1, 1'b0, 4'hF, 32'h802, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,        16'h0,    32'h0};
        vecs[7]  = '{1'b1, 1'b0, 4'hF, 32'h200, 32'h0,        1'b1, 1'b0, 1'b1, 32'h810,      16'h0,    32'h0};
        vecs[8]  = '{1'b1, 1'b1, 4'hF, 32'hC00, 32'h1234,     1'b1, 1'b0, 1'b0, 32'h0,        16'h1234, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 4'hF, 32'hC04, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        16'h1234, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 1'b0, 4'hF, 32'hC04, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'h1234, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 1'b0, 4'hF, 32'hC00, 32'h0,        1'b1, 1'b0, 1'b1, 32'h1234,     16'h1234, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 1'b1, 4'hF, 32'hC08, 32'h5,        1'b1, 1'b1, 1'b1, 32'h0,        16'h1234, 32'hDEADBEEF};
        vecs[13] = '{1'b1, 1'b1, 4'h0, 32'h804, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0,        16'h1234, 32'hDEADBEEF};
        vecs[14] = '{1'b1, 1'b0, 4'hF, 32'h804, 32'h0,        1'b1, 1'b0, 1'b1, 32'h00BB00DD, 16'h1234, 32'hDEADBEEF};
        vecs[15] = '{1'b0, 1'b0, 4'h0, 32'h000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'h1234, 32'hDEADBEEF};

        // Memory contents are not reset: preload both arrays and mirror them in the model
        for (int i = 0; i < CD; i++) begin
            m_rom[i] = (i == 0) ? 32'h810 : $urandom;
            dut.u_const_rom.mem[i] = m_rom[i];
        end
        for (int i = 0; i < VD; i++) begin
            m_ram[i] = 32'h0;
            dut.u_var_ram.mem[i] = 32'h0;
        end

        RESET_N = 1'b0; REQ = 1'b0; WE = 1'b0; BE = 4'h0; ADDR = 32'h0; WDATA = 32'h0; DIP = 7'h0;
        edges = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", {31'h0, READY}, 32'h0);
        check("rst_fault", {31'h0, FAULT}, 32'h0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_led", {16'h0, LED}, 32'h0);
        check("rst_sseg", SEVENSEGHEX, 32'h0);
        RESET_N = 1'b1;
        model_reset();

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_ready", i), {31'h0, READY}, {31'h0, vecs[i].exp_ready});
            if (vecs[i].exp_ready)
                check($sformatf("vec%0d_fault", i), {31'h0, FAULT}, {31'h0, vecs[i].exp_fault});
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rdata", i), RDATA, vecs[i].exp_rdata);
            check($sformatf("vec%0d_led", i), {16'h0, LED}, {16'h0, vecs[i].exp_led});
            check($sformatf("vec%0d_sseg", i), SEVENSEGHEX, vecs[i].exp_sseg);
        end

        // DIP synchroniser lag: back-to-back reads after the pins change
        DIP = 7'h55;
        step(1'b1, 1'b0, 4'hF, 32'hC08, 32'h0);
        check("dip_lag1", RDATA, 32'h0);
        step(1'b1, 1'b0, 4'hF, 32'hC08, 32'h0);
        check("dip_lag2", RDATA, 32'h0);
        step(1'b1, 1'b0, 4'hF, 32'hC08, 32'h0);
        check("dip_lag3", RDATA, 32'h55);

        // CYCLES clear beats increment, then counts elapsed edges
        step(1'b1, 1'b1, 4'hF, 32'hC0C, 32'h12345678);
        step(1'b1, 1'b0, 4'hF, 32'hC0C, 32'h0);
        check("cyc_after_clear", RDATA, 32'h0);
        repeat (4) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'hF, 32'hC0C, 32'h0);
        check("cyc_elapsed", RDATA, 32'h5);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) DIP = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 5))
                0:       a = CB + 4 * $urandom_range(0, CD - 1);
                1, 5:    a = VB + 4 * $urandom_range(0, VD - 1);
                2:       a = IOB + 4 * $urandom_range(0, 3);
                3:       a = 32'h1000 + 4 * $urandom_range(0, 255);
                default: a = VB + 4 * $urandom_range(0, VD - 1) + $urandom_range(1, 3);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), a, $urandom);
        end

        // Reset during a read response: READY drops at once, committed RAM data survives
        step(1'b1, 1'b1, 4'hF, 32'h808, 32'h11223344);
        step(1'b1, 1'b0, 4'hF, 32'h808, 32'h0);
        check("pre_rst_ready", {31'h0, READY}, 32'h1);
        REQ = 1'b0;
        #1 RESET_N = 1'b0;
        #1;
        check("mid_rst_ready", {31'h0, READY}, 32'h0);
        check("mid_rst_rdata", RDATA, 32'h0);
        check("mid_rst_led", {16'h0, LED}, 32'h0);
        RESET_N = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 4'hF, 32'h808, 32'h0);
        check("post_rst_rdata", RDATA, 32'h11223344);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
